// File: rtl/dcpu_int_queue.sv
// Interrupt queue ahead of the DCPU-16 core: merges INT and device
// interrupts into a FIFO and hands one message at a time to the core.
module dcpu_int_queue #(
  parameter int DEPTH = 256,
  parameter int N_DEV = 4
) (
  input  logic               CORE_CLK,
  input  logic               RESET,
  input  logic               SWI_valid,
  input  logic [15:0]        SWI_msg,
  input  logic [N_DEV-1:0]   HWI_req,
  input  logic [16*N_DEV-1:0] HWI_msg,
  output logic [N_DEV-1:0]   HWI_ack,
  input  logic               IAQ,
  input  logic               IA_zero,
  output logic               INT_valid,
  output logic [15:0]        INT_msg,
  input  logic               INT_ready,
  output logic [8:0]         count,
  output logic               on_fire
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    DROP,
    FIRE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]    count_q, count_d;
  logic          on_fire_q, on_fire_d;
  logic [RW-1:0] rr_q, rr_d;
  logic [15:0]   int_msg_q, int_msg_d;
  logic [15:0]   mem_q [DEPTH];

  logic          hw_hit;
  logic [RW-1:0] hw_sel;
  logic          fire, hwi_push, push, pop;
  logic          full, overflow, wr_en;
  logic [15:0]   push_msg;

  // Round-robin search begins at rr_q, the device after the last grant.
  always_comb begin
    hw_hit = 1'b0;
    hw_sel = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (!hw_hit && HWI_req[(int'(rr_q) + k) % N_DEV]) begin
        hw_hit = 1'b1;
        hw_sel = RW'((int'(rr_q) + k) % N_DEV);
      end
    end
  end

  always_comb begin
    fire     = (state_q == FIRE);
    hwi_push = hw_hit && !fire && !SWI_valid;
    push     = (SWI_valid && !fire) || hwi_push;
    push_msg = SWI_valid ? SWI_msg
                         : HWI_msg[int'(hw_sel)*16 +: 16];
    pop      = ((state_q == PRESENT) && INT_ready) ||
               (state_q == DROP);
    full     = (count_q == 9'(DEPTH));
    overflow = push && full && !pop;
    wr_en    = push && !overflow;

    HWI_ack  = hwi_push ? (N_DEV'(1) << hw_sel) : '0;
    rr_d     = hwi_push ? RW'((int'(hw_sel) + 1) % N_DEV) : rr_q;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop) count_d = count_q + 9'd1;
    if (!wr_en && pop) count_d = count_q - 9'd1;

    on_fire_d = on_fire_q || overflow;
  end

  always_comb begin
    state_d   = state_q;
    int_msg_d = int_msg_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          if (IA_zero)   state_d = DROP;
          else if (!IAQ) state_d = PRESENT;
        end
      end
      PRESENT: if (INT_ready) state_d = IDLE;
      DROP:    state_d = IDLE;
      FIRE:    state_d = FIRE;
      default: state_d = IDLE;
    endcase
    if (on_fire_d) state_d = FIRE;
    // Latch the head once on entry so it stays stable while presented.
    if (state_q == IDLE && state_d == PRESENT)
      int_msg_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge CORE_CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      on_fire_q <= 1'b0;
      rr_q      <= '0;
      int_msg_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      on_fire_q <= on_fire_d;
      rr_q      <= rr_d;
      int_msg_q <= int_msg_d;
    end
  end

  always_ff @(posedge CORE_CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_msg;
  end

  assign INT_valid = (state_q == PRESENT);
  assign INT_msg   = int_msg_q;
  assign count     = count_q;
  assign on_fire   = on_fire_q;

endmodule

// File: tb/tb_dcpu_int_queue.sv
// Scoreboard bench for dcpu_int_queue: expected messages are queued
// when driven and compared as the core side takes them.
module tb_dcpu_int_queue;

  localparam int DEPTH = 256;
  localparam int N_DEV = 4;

  logic        CORE_CLK;
  logic        RESET;
  logic        SWI_valid;
  logic [15:0] SWI_msg;
  logic [3:0]  HWI_req;
  logic [63:0] HWI_msg;
  logic [3:0]  HWI_ack;
  logic        IAQ;
  logic        IA_zero;
  logic        INT_valid;
  logic [15:0] INT_msg;
  logic        INT_ready;
  logic [8:0]  count;
  logic        on_fire;

  int total = 0;
  int bad = 0;
  logic [15:0] sb [$];

  dcpu_int_queue #(.DEPTH(DEPTH), .N_DEV(N_DEV)) dut (
    .CORE_CLK (CORE_CLK),
    .RESET    (RESET),
    .SWI_valid(SWI_valid),
    .SWI_msg  (SWI_msg),
    .HWI_req  (HWI_req),
    .HWI_msg  (HWI_msg),
    .HWI_ack  (HWI_ack),
    .IAQ      (IAQ),
    .IA_zero  (IA_zero),
    .INT_valid(INT_valid),
    .INT_msg  (INT_msg),
    .INT_ready(INT_ready),
    .count    (count),
    .on_fire  (on_fire)
  );

  initial CORE_CLK = 1'b0;
  always #5 CORE_CLK = ~CORE_CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CORE_CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    SWI_valid = 1'b0;
    SWI_msg = '0;
    HWI_req = '0;
    INT_ready = 1'b0;
    IAQ = 1'b1;
    IA_zero = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    sb.delete();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (INT_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain(input int n);
    bit ok;
    for (int j = 0; j < n; j++) begin
      wait_valid(ok);
      if (!ok) begin
        chk("valid_timeout", 32'd0, 32'd1);
      end else begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk("int_msg", 32'(INT_msg), 32'(sb.pop_front()));
        INT_ready = 1'b1;
        tick();
        INT_ready = 1'b0;
      end
    end
  endtask

  task automatic push_swi(input logic [15:0] m, input bit track);
    SWI_valid = 1'b1;
    SWI_msg = m;
    if (track) sb.push_back(m);
    tick();
    SWI_valid = 1'b0;
  endtask

  logic [3:0]  exp_ack [4];
  logic [15:0] exp_msg [4];
  bit seen_valid;
  bit ok;

  initial begin
    HWI_msg = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    do_reset();

    // reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(INT_valid), 32'd0);
    chk("rst_msg", 32'(INT_msg), 32'd0);
    chk("rst_fire", 32'(on_fire), 32'd0);
    chk("rst_ack", 32'(HWI_ack), 32'd0);

    // single SWI through the handshake
    IAQ = 1'b0;
    push_swi(16'h1234, 1'b1);
    chk("t1_count1", 32'(count), 32'd1);
    drain(1);
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_idle", 32'(INT_valid), 32'd0);

    // round-robin ack order with requests held
    do_reset();
    exp_ack = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_msg = '{16'hD000, 16'hD001, 16'hD003, 16'hD000};
    HWI_req = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ack", 32'(HWI_ack), 32'(exp_ack[i]));
      sb.push_back(exp_msg[i]);
      tick();
    end
    HWI_req = '0;
    chk("t2_count", 32'(count), 32'd4);
    IAQ = 1'b0;
    drain(4);
    chk("t2_empty", 32'(count), 32'd0);

    // SWI wins over a simultaneous HWI, which is acked a cycle later
    do_reset();
    SWI_valid = 1'b1;
    SWI_msg = 16'h5555;
    HWI_req = 4'b0100;
    #1;
    chk("t3_ack_wait", 32'(HWI_ack), 32'd0);
    sb.push_back(16'h5555);
    tick();
    SWI_valid = 1'b0;
    #1;
    chk("t3_ack2", 32'(HWI_ack), 32'b0100);
    sb.push_back(16'hD002);
    tick();
    HWI_req = '0;
    chk("t3_count", 32'(count), 32'd2);
    IAQ = 1'b0;
    drain(2);

    // IA==0 drops everything without presenting
    do_reset();
    for (int i = 0; i < 3; i++) push_swi(16'(16'hA0 + i), 1'b0);
    IAQ = 1'b0;
    IA_zero = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (INT_valid) seen_valid = 1'b1;
      tick();
    end
    chk("t4_novalid", 32'(seen_valid), 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    IA_zero = 1'b0;

    // overflow into the FIRE state
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_swi(16'(i), 1'b0);
    chk("t5_full", 32'(count), 32'(DEPTH));
    chk("t5_nofire", 32'(on_fire), 32'd0);
    HWI_req = 4'b0010;
    #1;
    chk("t5_ovf_ack", 32'(HWI_ack), 32'b0010);
    tick();
    chk("t5_fire", 32'(on_fire), 32'd1);
    chk("t5_cnt_ovf", 32'(count), 32'(DEPTH));
    #1;
    chk("t5_fire_ack", 32'(HWI_ack), 32'd0);
    HWI_req = '0;
    IAQ = 1'b0;
    INT_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (INT_valid) seen_valid = 1'b1;
      tick();
    end
    INT_ready = 1'b0;
    chk("t5_fire_valid", 32'(seen_valid), 32'd0);
    chk("t5_fire_cnt", 32'(count), 32'(DEPTH));
    do_reset();
    chk("t5_rst_fire", 32'(on_fire), 32'd0);
    chk("t5_rst_cnt", 32'(count), 32'd0);

    // push and pop together while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_swi(16'(16'h1000 + i), 1'b1);
    IAQ = 1'b0;
    wait_valid(ok);
    chk("t6_valid", 32'(ok), 32'd1);
    if (ok) begin
      chk("t6_head", 32'(INT_msg), 32'(sb.pop_front()));
      SWI_valid = 1'b1;
      SWI_msg = 16'hBEEF;
      INT_ready = 1'b1;
      sb.push_back(16'hBEEF);
      tick();
      SWI_valid = 1'b0;
      INT_ready = 1'b0;
      chk("t6_count", 32'(count), 32'(DEPTH));
      chk("t6_nofire", 32'(on_fire), 32'd0);
      drain(DEPTH);
      chk("t6_empty", 32'(count), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
